// File: rtl/reg_alu_pkg.sv
// Opcode and FSM state encodings shared by reg_alu_pipe and its bench.
package reg_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ADC  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_LOAD = 3'b111;

  localparam logic ST_RUN      = 1'b0;
  localparam logic ST_MUL_BUSY = 1'b1;

endpackage

// File: rtl/mul_seq.sv
// Shift-add multiplier, one multiplier bit per cycle; keeps the low WIDTH bits.
module mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_step;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      cnt_q    <= CNT_W'(WIDTH);
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
    end else if (cnt_q != '0) begin
      cnt_q    <= cnt_q - CNT_W'(1);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_step;
    end
  end

  // The last partial product is folded in combinationally so the result
  // is ready on the same edge that consumes the final multiplier bit.
  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CNT_W'(1));
  assign product = acc_step;

endmodule

// File: rtl/reg_alu_pipe.sv
// Register file + ALU with valid/ready issue, registered writeback with bypass,
// sticky carry/zero flags and an iterative multiply.
//   state       | meaning
//   ST_RUN      | accepting one instruction per cycle
//   ST_MUL_BUSY | multiply in flight, issue stalled
module reg_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              cout,
  output logic              zero,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  logic [WIDTH-1:0]  rf_q [DEPTH];
  logic              state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]  wb_data_q, wb_data_d;
  logic              cout_q, cout_d;
  logic              zero_q, zero_d;
  logic [ADDR_W-1:0] mul_dest_q;

  logic              accept, mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0]  mul_product;
  logic [WIDTH-1:0]  op_a, op_b, alu_r;
  logic              alu_c, alu_arith;
  logic [WIDTH:0]    add_w, sub_w;

  assign instr_ready = (state_q == ST_RUN);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    op_a = rf_q[rd_addr_a];
    op_b = rf_q[rd_addr_b];
    if (wb_valid_q && (wb_addr_q == rd_addr_a)) op_a = wb_data_q;
    if (wb_valid_q && (wb_addr_q == rd_addr_b)) op_b = wb_data_q;
  end

  assign add_w = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, (op == OP_ADC) && cout_q};
  assign sub_w = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    alu_r     = d_in;
    alu_c     = cout_q;
    alu_arith = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin alu_r = add_w[WIDTH-1:0]; alu_c = add_w[WIDTH]; alu_arith = 1'b1; end
      OP_SUB:         begin alu_r = sub_w[WIDTH-1:0]; alu_c = ~sub_w[WIDTH]; alu_arith = 1'b1; end
      OP_AND:         alu_r = op_a & op_b;
      OP_OR:          alu_r = op_a | op_b;
      OP_XOR:         alu_r = op_a ^ op_b;
      default:        alu_r = d_in;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    cout_d     = cout_q;
    zero_d     = zero_q;
    mul_start  = 1'b0;
    if (state_q == ST_MUL_BUSY) begin
      if (mul_done) begin
        wb_valid_d = 1'b1;
        wb_addr_d  = mul_dest_q;
        wb_data_d  = mul_product;
        zero_d     = (mul_product == '0);
        state_d    = ST_RUN;
      end else if (!mul_busy) begin
        state_d = ST_RUN;
      end
    end else if (accept) begin
      if (op == OP_MUL) begin
        mul_start = 1'b1;
        state_d   = ST_MUL_BUSY;
      end else begin
        wb_valid_d = 1'b1;
        wb_addr_d  = wr_addr;
        wb_data_d  = alu_r;
        if (op != OP_LOAD) zero_d = (alu_r == '0);
        if (alu_arith)     cout_d = alu_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      state_q    <= ST_RUN;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      mul_dest_q <= '0;
    end else begin
      if (wb_valid_q) rf_q[wb_addr_q] <= wb_data_q;
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      if (mul_start) mul_dest_q <= wr_addr;
    end
  end

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed bench for reg_alu_pipe: architectural model feeds a writeback scoreboard.
module tb_reg_alu_pipe;
  import reg_alu_pkg::*;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, dbg_addr = '0;
  logic [W-1:0]  d_in = '0;
  logic          instr_ready, wb_valid, cout, zero;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data, dbg_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]    m_rf [D];
  logic            m_cout, m_zero;
  logic [AW+W-1:0] exp_q [$];

  always #20 clk = ~clk;

  reg_alu_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
    .d_in(d_in), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .cout(cout), .zero(zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; any writeback seen is matched against the scoreboard.
  task automatic step();
    logic [AW+W-1:0] e;
    @(posedge clk);
    #1;
    if (wb_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wb_unexpected observed addr=%h data=%h expected none", wb_addr, wb_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(e[W +: AW]));
        chk("wb_data", 32'(wb_data), 32'(e[W-1:0]));
      end
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [AW-1:0] rw, input logic [W-1:0] d);
    logic [W-1:0]   a, b, r;
    logic [W:0]     t;
    logic [2*W-1:0] p;
    a = m_rf[ra];
    b = m_rf[rb];
    r = '0;
    case (o)
      OP_ADD:  begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; m_cout = t[W]; end
      OP_ADC:  begin t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, m_cout}; r = t[W-1:0]; m_cout = t[W]; end
      OP_SUB:  begin r = a - b; m_cout = (a >= b); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MUL:  begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
      default: r = d;
    endcase
    if (o != OP_LOAD) m_zero = (r == '0);
    m_rf[rw] = r;
    exp_q.push_back({rw, r});
  endtask

  task automatic drive(input logic [2:0] o, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [AW-1:0] rw, input logic [W-1:0] d);
    instr_valid = 1'b1;
    op = o; rd_addr_a = ra; rd_addr_b = rb; wr_addr = rw; d_in = d;
  endtask

  task automatic issue(input logic [2:0] o, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [AW-1:0] rw, input logic [W-1:0] d);
    drive(o, ra, rb, rw, d);
    model(o, ra, rb, rw, d);
    step();
    instr_valid = 1'b0;
  endtask

  task automatic dbg_chk(input logic [AW-1:0] a, input logic [W-1:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_r%0d", a), 32'(dbg_data), 32'(exp));
  endtask

  task automatic chk_rf();
    for (int i = 0; i < D; i++) dbg_chk(AW'(i), m_rf[i]);
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_cout"}, 32'(cout), 32'(m_cout));
    chk({tag, "_zero"}, 32'(zero), 32'(m_zero));
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_rf[i] = '0;
    m_cout = 1'b0;
    m_zero = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int lat;
    int pulses;
    model_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk_flags("rst");
    chk_rf();

    // Loads back to back, then ADD using the in-flight r2 via bypass.
    issue(OP_LOAD, 3'd0, 3'd0, 3'd1, 16'h00FF);
    chk("ld1_ready", 32'(instr_ready), 32'd1);
    chk("ld1_wbv", 32'(wb_valid), 32'd1);
    issue(OP_LOAD, 3'd0, 3'd0, 3'd2, 16'hFF01);
    chk("ld2_ready", 32'(instr_ready), 32'd1);
    chk("ld2_wbv", 32'(wb_valid), 32'd1);
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0);
    chk("add_wbdata", 32'(wb_data), 32'h0000);
    chk("add_cout", 32'(cout), 32'd1);
    chk("add_zero", 32'(zero), 32'd1);
    dbg_chk(3'd1, 16'h00FF);
    dbg_chk(3'd2, 16'hFF01);
    issue(OP_ADC, 3'd1, 3'd1, 3'd4, 16'h0);
    chk("adc_wbdata", 32'(wb_data), 32'h01FF);
    chk("adc_cout", 32'(cout), 32'd0);
    chk("adc_zero", 32'(zero), 32'd0);
    issue(OP_SUB, 3'd1, 3'd2, 3'd5, 16'h0);
    chk("sub1_wbdata", 32'(wb_data), 32'h01FE);
    chk("sub1_cout", 32'(cout), 32'd0);
    issue(OP_SUB, 3'd2, 3'd1, 3'd6, 16'h0);
    chk("sub2_wbdata", 32'(wb_data), 32'hFE02);
    chk("sub2_cout", 32'(cout), 32'd1);
    step();
    chk_rf();

    // MUL with a dependent ADD held on the bus until the issue stall lifts.
    drive(OP_MUL, 3'd1, 3'd1, 3'd7, 16'h0);
    model(OP_MUL, 3'd1, 3'd1, 3'd7, 16'h0);
    step();
    drive(OP_ADD, 3'd7, 3'd1, 3'd0, 16'h0);
    lat = 0;
    while (instr_ready !== 1'b1 && lat < 40) begin
      chk("mul_wbv_low", 32'(wb_valid), 32'd0);
      lat++;
      step();
    end
    chk("mul_latency", 32'(lat), 32'd16);
    chk("mul_wbv", 32'(wb_valid), 32'd1);
    chk("mul_wbdata", 32'(wb_data), 32'hFE01);
    chk_flags("mul");
    model(OP_ADD, 3'd7, 3'd1, 3'd0, 16'h0);
    step();
    instr_valid = 1'b0;
    chk("mul_bypass_add", 32'(wb_data), 32'hFF00);
    chk_flags("mul_add");
    step();
    chk_rf();

    // Logic ops keep carry; LOAD of zero leaves both flags alone.
    issue(OP_SUB, 3'd6, 3'd1, 3'd3, 16'h0);
    chk_flags("sub3");
    issue(OP_AND, 3'd1, 3'd6, 3'd2, 16'h0);
    chk_flags("and");
    issue(OP_XOR, 3'd1, 3'd1, 3'd4, 16'h0);
    chk_flags("xor");
    issue(OP_OR, 3'd4, 3'd1, 3'd5, 16'h0);
    chk_flags("or");
    issue(OP_LOAD, 3'd0, 3'd0, 3'd4, 16'h0000);
    chk_flags("load0");
    issue(OP_LOAD, 3'd0, 3'd0, 3'd7, 16'h01FE);
    issue(OP_ADD, 3'd6, 3'd7, 3'd3, 16'h0);
    chk_flags("add_wrap");
    pulses = (wb_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wb_valid === 1'b1) pulses++;
    end
    chk("idle_pulses", 32'(pulses), 32'd1);
    chk_flags("idle");
    chk_rf();

    // Same-address sources and destination, back to back.
    issue(OP_ADD, 3'd6, 3'd6, 3'd6, 16'h0);
    issue(OP_ADD, 3'd6, 3'd6, 3'd6, 16'h0);
    chk_flags("same_addr");
    step();
    chk_rf();

    // Reset in the middle of a multiply: no writeback may survive.
    issue(OP_MUL, 3'd6, 3'd6, 3'd5, 16'h0);
    for (int i = 0; i < 5; i++) step();
    chk("mulrst_ready_low", 32'(instr_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("mulrst_ready", 32'(instr_ready), 32'd1);
    chk("mulrst_wbv", 32'(wb_valid), 32'd0);
    chk_flags("mulrst");
    chk_rf();
    for (int i = 0; i < 20; i++) step();
    chk_rf();
    issue(OP_LOAD, 3'd0, 3'd0, 3'd1, 16'h0005);
    issue(OP_ADD, 3'd1, 3'd1, 3'd2, 16'h0);
    chk_flags("resume");
    step();
    chk_rf();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
